linebuffer_scanout: RTL
=======================

// Module: linebuffer_scanout
// PURPOSE
// - Read-side engine for the 128x128-bit pixel linebuffer. Runs in the pixel clock domain.
// - On each line_start, fetches 16-pixel words from one line bank through the BRAM read port.
// - Applies fine horizontal scroll and integer pixel repeat.
// - Streams one 8-bit palette index per clock to the palette/DAC stage.
// - The draw side fills the other bank; bank ownership is swapped by the caller.
// PARAMETERS
// - ACTIVE_PX  640  output pixels per line (after repeat). Must be a multiple of HSCALE.
// - HSCALE     1    output clocks per source pixel. Legal: 1, 2, 4.
// PORTS
// - clk_pix     in   1    pixel clock; all logic is on its rising edge
// - rst_pix     in   1    synchronous, active-high reset
// - line_start  in   1    one-cycle pulse; begins (or restarts) a line
// - bank        in   1    line bank; sampled when line_start=1
// - fine        in   4    source pixel offset 0..15 into word 0; sampled when line_start=1
// - addr_pix    out  7    BRAM read address, registered: {bank, word[5:0]}
// - colour_pix  in   128  BRAM read data; valid 1 clock after addr_pix is presented
//                         pixel k of a word = colour_pix[8k+7:8k]
// - pixel       out  8    palette index, registered
// - pixel_valid out  1    pixel is an active-display pixel
// - line_done   out  1    one-cycle pulse, the cycle after the last valid pixel
// BEHAVIOUR
// - Reset values: addr_pix=0, pixel=0, pixel_valid=0, line_done=0, FSM=IDLE.
//   Reset wins over line_start in the same cycle.
// - FSM states:
//   - IDLE: outputs quiet.
//   - FILL: word 0 in flight.
//   - RUN: streaming.
//   - Transitions: IDLE->FILL on line_start; FILL->RUN after 2 cycles;
//     RUN->IDLE after the ACTIVE_PX-th output pixel; any state->FILL on line_start.
// - Timing:
//   - line_start high in cycle T: addr_pix={bank,0} in T+1; colour_pix of word 0 valid in T+2.
//   - Shifter is loaded in T+2. The first pixel appears in T+3 with pixel_valid=1.
//   - pixel_valid then stays 1 for exactly ACTIVE_PX consecutive cycles; no gaps.
// - Source pixel sequence: starts at source index fine (word 0, byte fine).
//   - Increments by 1 every HSCALE cycles.
//   - Crosses into word n+1 after byte 15 of word n.
//   - Total source pixels consumed = ACTIVE_PX/HSCALE.
// - Prefetch:
//   - Holds a one-word next buffer.
//   - Word n+1 is requested the cycle after word n loads into the shifter, so the next buffer is full before the shifter empties.
//   - Underrun is impossible at HSCALE=1 and must not occur.
//   - Word index is 6 bits and wraps 63->0 within the same bank.
// - Bank and fine are latched at line_start. Later changes to these inputs do not affect the current line.
// - line_start while in FILL or RUN:
//   - Current line is abandoned; pixel_valid=0 from the next cycle.
//   - line_done is not pulsed for the abandoned line.
//   - New line timing is exactly as from IDLE.
// - line_done:
//   - Pulses in the cycle after the final valid pixel.
//   - Suppressed if line_start coincides with that cycle; the restart takes priority.
// - When pixel_valid=0, pixel is driven to 0.
// - Reads are fetch-only; no writes to the linebuffer.
// TESTING
// - Basic: HSCALE=1, ACTIVE_PX=640, bank=0, fine=0, BRAM word w byte k = (16w+k)&0xFF.
//   Pulse line_start at T.
//   Expect: first valid at T+3 with pixel=0x00; pixels 0..639 mod 256 contiguous;
//   line_done at T+643; addr_pix 0..39 only.
// - Fine scroll: fine=5, bank=1.
//   Expect: first pixel=0x05; addr_pix MSB=1; word 40 read;
//   last pixel=(644)&0xFF=0x84.
// - Repeat: HSCALE=2, fine=0.
//   Expect: each value held 2 cycles (00,00,01,01,...); 640 valid cycles; last pixel=0x3F (source 319).
// - Restart: line_start again at T+100 with fine=3.
//   Expect: pixel_valid low T+101..T+102; new line begins T+103 with pixel=0x03;
//   no line_done for the first line.
// - Reset mid-line: rst_pix at T+50.
//   Expect: all outputs 0 next cycle; no line_done; next line_start behaves as Basic.
// - Back-to-back: line_start in the line_done cycle.
//   Expect: line_done suppressed; new line first pixel 3 cycles later.

Source files
------------

// File: rtl/linebuffer_scanout.sv
// Linebuffer read-side engine: fetches 16-pixel words from one bank, applies fine scroll
// and integer pixel repeat, and streams one palette index per pixel clock.
module linebuffer_scanout #(
    parameter int ACTIVE_PX = 640,
    parameter int HSCALE    = 1
) (
    input  logic         clk_pix,
    input  logic         rst_pix,
    input  logic         line_start,
    input  logic         bank,
    input  logic [3:0]   fine,
    output logic [6:0]   addr_pix,
    input  logic [127:0] colour_pix,
    output logic [7:0]   pixel,
    output logic         pixel_valid,
    output logic         line_done
);

    localparam int SRC_PX = ACTIVE_PX / HSCALE;
    localparam int CW     = $clog2(ACTIVE_PX + 1);
    localparam int RW     = (HSCALE > 1) ? $clog2(HSCALE) : 1;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t         state_reg, state_next;
    logic           bank_reg;
    logic [3:0]     fine_reg;
    logic [15:0]    last_word_reg;
    logic [15:0]    fetch_idx_reg;
    logic           rd_req_reg;
    logic           rd_vld_reg;
    logic           fill_cnt_reg;
    logic [127:0]   cur_word_reg;
    logic [127:0]   next_word_reg;
    logic           next_full_reg;
    logic [3:0]     byte_idx_reg;
    logic [RW-1:0]  rep_reg;
    logic [CW-1:0]  out_cnt_reg;
    logic [6:0]     addr_reg;
    logic [7:0]     pixel_reg;
    logic           valid_reg;
    logic           done_reg;

    logic           last_out;
    logic           advance;
    logic           word_switch;
    logic           do_fetch;
    logic [127:0]   switch_src;

    function automatic logic [7:0] byte_of(input logic [127:0] w, input logic [3:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

    always_comb begin
        last_out    = (out_cnt_reg == CW'(ACTIVE_PX));
        advance     = (state_reg == RUN) && !last_out && (rep_reg == RW'(HSCALE - 1));
        word_switch = advance && (byte_idx_reg == 4'd15);
        // Word 1 is requested right behind word 0 so a fine=15 line cannot underrun.
        do_fetch    = (fetch_idx_reg <= last_word_reg) &&
                      (((state_reg == FILL) && !fill_cnt_reg) || word_switch);
        // A word arriving in the very cycle it is needed bypasses the next buffer.
        switch_src  = next_full_reg ? next_word_reg : colour_pix;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = IDLE;
            FILL:    if (fill_cnt_reg) state_next = RUN;
            RUN:     if (last_out) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (line_start) state_next = FILL;
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            bank_reg      <= 1'b0;
            fine_reg      <= '0;
            last_word_reg <= '0;
            fetch_idx_reg <= '0;
            rd_req_reg    <= 1'b0;
            rd_vld_reg    <= 1'b0;
            fill_cnt_reg  <= 1'b0;
            cur_word_reg  <= '0;
            next_word_reg <= '0;
            next_full_reg <= 1'b0;
            byte_idx_reg  <= '0;
            rep_reg       <= '0;
            out_cnt_reg   <= '0;
            addr_reg      <= '0;
            pixel_reg     <= '0;
            valid_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            rd_vld_reg <= rd_req_reg;
            rd_req_reg <= do_fetch;
            done_reg   <= 1'b0;
            if (do_fetch) begin
                addr_reg      <= {bank_reg, fetch_idx_reg[5:0]};
                fetch_idx_reg <= fetch_idx_reg + 16'd1;
            end
            if (line_start) begin
                bank_reg      <= bank;
                fine_reg      <= fine;
                last_word_reg <= (16'(fine) + 16'(SRC_PX - 1)) >> 4;
                addr_reg      <= {bank, 6'd0};
                fetch_idx_reg <= 16'd1;
                rd_req_reg    <= 1'b1;
                rd_vld_reg    <= 1'b0;
                fill_cnt_reg  <= 1'b0;
                next_full_reg <= 1'b0;
                out_cnt_reg   <= '0;
                pixel_reg     <= '0;
                valid_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    FILL: begin
                        fill_cnt_reg <= 1'b1;
                        if (fill_cnt_reg) begin
                            cur_word_reg <= colour_pix;
                            byte_idx_reg <= fine_reg;
                            rep_reg      <= '0;
                            out_cnt_reg  <= CW'(1);
                            pixel_reg    <= byte_of(colour_pix, fine_reg);
                            valid_reg    <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (rd_vld_reg && !word_switch) begin
                            next_word_reg <= colour_pix;
                            next_full_reg <= 1'b1;
                        end
                        if (last_out) begin
                            valid_reg <= 1'b0;
                            pixel_reg <= '0;
                            done_reg  <= 1'b1;
                        end else begin
                            out_cnt_reg <= out_cnt_reg + CW'(1);
                            if (advance) begin
                                rep_reg <= '0;
                                if (word_switch) begin
                                    cur_word_reg  <= switch_src;
                                    byte_idx_reg  <= 4'd0;
                                    pixel_reg     <= switch_src[7:0];
                                    next_full_reg <= 1'b0;
                                end else begin
                                    byte_idx_reg <= byte_idx_reg + 4'd1;
                                    pixel_reg    <= byte_of(cur_word_reg, byte_idx_reg + 4'd1);
                                end
                            end else begin
                                rep_reg <= rep_reg + RW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign addr_pix    = addr_reg;
    assign pixel       = pixel_reg;
    assign pixel_valid = valid_reg;
    // A restart landing on the done cycle takes priority over the done pulse.
    assign line_done   = done_reg & ~line_start;

endmodule
